udp_tx: RTL and testbench

UDP_TX -- requirements
Module: udp_tx

---
 rtl/udp_tx.sv | 235 +++++++++++++++++++++++
 tb/tb_udp_tx.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx.sv
// udp_tx: buffers a UDP payload, computes the UDP checksum over the IPv4
// pseudo-header, header and payload, then serializes header and payload
// MSB-first, N bits per cycle, with a one-cycle done pulse at the end.
module udp_tx #(
    parameter int N         = 2,
    parameter int MAX_BYTES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  src_ip_in,
    input  logic [31:0]  dst_ip_in,
    input  logic [15:0]  src_port_in,
    input  logic [15:0]  dst_port_in,
    input  logic [15:0]  payload_len_in,
    input  logic         axiiv,
    input  logic [7:0]   axiid,
    output logic         axiir,
    output logic         axiov,
    output logic [N-1:0] axiod,
    output logic         done,
    output logic         err
);

    localparam int          AW        = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam logic [6:0]  HDR_LAST  = 7'(64 / N - 1);
    localparam logic [3:0]  BYTE_LAST = 4'(8 / N - 1);
    localparam logic [15:0] MAX_LEN   = 16'(MAX_BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SUM1, S_SUM2, S_SUM3, S_HDR, S_PAY
    } state_t;

    state_t r_state;
    state_t w_next;

    // Latched segment metadata
    logic [31:0] r_src_ip;
    logic [31:0] r_dst_ip;
    logic [15:0] r_src_port;
    logic [15:0] r_dst_port;
    logic [15:0] r_len;
    logic [15:0] r_udp_len;

    // Checksum accumulator and reduction partials
    logic [15:0] r_acc;
    logic [15:0] r_p_a, r_p_b, r_p_c, r_p_d, r_p_e, r_p_f, r_p_g;

    // Counters
    logic [15:0] r_wr_cnt;
    logic [6:0]  r_hdr_cnt;
    logic [3:0]  r_bit_cnt;
    logic [15:0] r_byte_cnt;

    // Serializer state and payload buffer
    logic [63:0] r_hdr_sr;
    logic [7:0]  r_byte_sr;
    logic [7:0]  r_buf [MAX_BYTES];

    logic r_done;
    logic r_err;

    logic          w_start_ok;
    logic          w_start_bad;
    logic          w_accept;
    logic          w_load_last;
    logic          w_hdr_last;
    logic          w_byte_end;
    logic          w_pay_last;
    logic          w_tx_last;
    logic [15:0]   w_pay_word;
    logic [15:0]   w_sum_raw;
    logic [15:0]   w_csum;
    logic [AW-1:0] w_wr_addr;
    logic [AW-1:0] w_rd_addr;

    // One's-complement 16-bit add with end-around carry; the fold cannot
    // overflow because a carry implies the low 16 bits are at most 0xFFFE.
    function automatic logic [15:0] f_oc_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[15:0] + {15'd0, sum[16]};
    endfunction

    assign w_start_ok  = start && (payload_len_in <= MAX_LEN);
    assign w_start_bad = start && (payload_len_in > MAX_LEN);
    assign w_accept    = (r_state == S_LOAD) && axiiv;
    assign w_load_last = w_accept && (r_wr_cnt == r_len - 16'd1);
    assign w_hdr_last  = (r_state == S_HDR) && (r_hdr_cnt == HDR_LAST);
    assign w_byte_end  = (r_bit_cnt == BYTE_LAST);
    assign w_pay_last  = (r_state == S_PAY) && w_byte_end && (r_byte_cnt == r_len - 16'd1);
    assign w_tx_last   = (w_hdr_last && (r_len == 16'd0)) || w_pay_last;
    // Even offsets are the high byte of a word; an odd trailing byte is thereby zero-padded
    assign w_pay_word  = r_wr_cnt[0] ? {8'h00, axiid} : {axiid, 8'h00};
    assign w_sum_raw   = f_oc_add(f_oc_add(r_p_f, r_p_g), r_p_e);
    // A computed checksum of zero is sent as 0xFFFF (all-ones means "zero" too)
    assign w_csum      = (w_sum_raw == 16'hFFFF) ? 16'hFFFF : ~w_sum_raw;
    assign w_wr_addr   = r_wr_cnt[AW-1:0];
    assign w_rd_addr   = AW'(r_byte_cnt + 16'd1);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start_ok) w_next = (payload_len_in == 16'd0) ? S_SUM1 : S_LOAD;
            S_LOAD: if (w_load_last) w_next = S_SUM1;
            S_SUM1: w_next = S_SUM2;
            S_SUM2: w_next = S_SUM3;
            S_SUM3: w_next = S_HDR;
            S_HDR:  if (w_hdr_last) w_next = (r_len == 16'd0) ? S_IDLE : S_PAY;
            S_PAY:  if (w_pay_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode from state and serializer registers
    always_comb begin
        axiir = (r_state == S_LOAD);
        axiov = (r_state == S_HDR) || (r_state == S_PAY);
        axiod = '0;
        if (r_state == S_HDR) begin
            axiod = r_hdr_sr[63 -: N];
        end else if (r_state == S_PAY) begin
            axiod = r_byte_sr[7 -: N];
        end
        done = r_done;
        err  = r_err;
    end

    // Control: accumulator, counters and status pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc      <= '0;
            r_wr_cnt   <= '0;
            r_hdr_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= w_tx_last;
            r_err  <= (r_state == S_IDLE) && w_start_bad;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_acc     <= '0;
                        r_wr_cnt  <= '0;
                        r_hdr_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_acc    <= f_oc_add(r_acc, w_pay_word);
                        r_wr_cnt <= r_wr_cnt + 16'd1;
                    end
                end
                S_HDR: begin
                    if (w_hdr_last) begin
                        r_hdr_cnt  <= '0;
                        r_bit_cnt  <= '0;
                        r_byte_cnt <= '0;
                    end else begin
                        r_hdr_cnt <= r_hdr_cnt + 7'd1;
                    end
                end
                S_PAY: begin
                    if (w_byte_end) begin
                        r_bit_cnt  <= '0;
                        r_byte_cnt <= r_byte_cnt + 16'd1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath: metadata capture, buffer writes, checksum reduction, shifters
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[w_wr_addr] <= axiid;
        end
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    r_src_ip   <= src_ip_in;
                    r_dst_ip   <= dst_ip_in;
                    r_src_port <= src_port_in;
                    r_dst_port <= dst_port_in;
                    r_len      <= payload_len_in;
                    r_udp_len  <= payload_len_in + 16'd8;
                end
            end
            S_SUM1: begin
                r_p_a <= f_oc_add(r_src_ip[31:16], r_src_ip[15:0]);
                r_p_b <= f_oc_add(r_dst_ip[31:16], r_dst_ip[15:0]);
                r_p_c <= f_oc_add(16'h0011, r_udp_len);
                r_p_d <= f_oc_add(r_src_port, r_dst_port);
                r_p_e <= f_oc_add(r_udp_len, r_acc);
            end
            S_SUM2: begin
                r_p_f <= f_oc_add(r_p_a, r_p_b);
                r_p_g <= f_oc_add(r_p_c, r_p_d);
            end
            S_SUM3: begin
                r_hdr_sr <= {r_src_port, r_dst_port, r_udp_len, w_csum};
            end
            S_HDR: begin
                r_hdr_sr <= r_hdr_sr << N;
                if (w_hdr_last) begin
                    r_byte_sr <= r_buf[0];
                end
            end
            S_PAY: begin
                if (w_byte_end && !w_pay_last) begin
                    r_byte_sr <= r_buf[w_rd_addr];
                end else begin
                    r_byte_sr <= r_byte_sr << N;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_udp_tx.sv
// tb_udp_tx: directed scenarios for udp_tx with a queue-based scoreboard.
module tb_udp_tx;

    localparam int N   = 2;
    localparam int MAX = 64;
    localparam int CPB = 8 / N;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  src_ip_in = '0;
    logic [31:0]  dst_ip_in = '0;
    logic [15:0]  src_port_in = '0;
    logic [15:0]  dst_port_in = '0;
    logic [15:0]  payload_len_in = '0;
    logic         axiiv = 1'b0;
    logic [7:0]   axiid = '0;
    logic         axiir;
    logic         axiov;
    logic [N-1:0] axiod;
    logic         done;
    logic         err;

    udp_tx #(.N(N), .MAX_BYTES(MAX)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_ip_in(src_ip_in), .dst_ip_in(dst_ip_in),
        .src_port_in(src_port_in), .dst_port_in(dst_port_in),
        .payload_len_in(payload_len_in),
        .axiiv(axiiv), .axiid(axiid), .axiir(axiir),
        .axiov(axiov), .axiod(axiod), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { int first; int ncyc; } seg_t;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         ir_cnt   = 0;
    int         exp_err  = 0;
    logic [7:0] exp_q [$];
    seg_t       seg_q [$];
    logic [7:0] pay [0:127];

    logic [7:0] v_basic [10] = '{8'hA4, 8'h55, 8'h02, 8'h2A, 8'h00, 8'h0A, 8'hD5, 8'h04, 8'h01, 8'h02};
    logic [7:0] v_odd   [9]  = '{8'hA4, 8'h55, 8'h02, 8'h2A, 8'h00, 8'h09, 8'hD7, 8'h07, 8'hFF};
    logic [7:0] v_zero  [8]  = '{8'hA4, 8'h55, 8'h02, 8'h2A, 8'h00, 8'h08, 8'hD6, 8'h0A};
    logic [7:0] v_zcs   [8]  = '{8'hFF, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h08, 8'hFF, 8'hFF};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference checksum: wide sum of all 16-bit words, folded at the end
    function automatic logic [15:0] model_csum(input logic [31:0] sip, input logic [31:0] dip,
                                               input logic [15:0] sp, input logic [15:0] dp,
                                               input int len);
        logic [31:0] s;
        logic [15:0] ul;
        logic [15:0] c;
        ul = 16'(len + 8);
        s  = 32'(sip[31:16]) + 32'(sip[15:0]) + 32'(dip[31:16]) + 32'(dip[15:0]);
        s  = s + 32'h11 + 32'(ul) + 32'(sp) + 32'(dp) + 32'(ul);
        for (int i = 0; i < len; i++) begin
            if (i % 2 == 0) s = s + {16'h0, pay[i], 8'h00};
            else            s = s + {24'h0, pay[i]};
        end
        while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        c = ~s[15:0];
        return (c == 16'h0) ? 16'hFFFF : c;
    endfunction

    task automatic push_model(input logic [31:0] sip, input logic [31:0] dip,
                              input logic [15:0] sp, input logic [15:0] dp, input int len);
        logic [15:0] ul;
        logic [15:0] cs;
        ul = 16'(len + 8);
        cs = model_csum(sip, dip, sp, dp, len);
        exp_q.push_back(sp[15:8]); exp_q.push_back(sp[7:0]);
        exp_q.push_back(dp[15:8]); exp_q.push_back(dp[7:0]);
        exp_q.push_back(ul[15:8]); exp_q.push_back(ul[7:0]);
        exp_q.push_back(cs[15:8]); exp_q.push_back(cs[7:0]);
        for (int i = 0; i < len; i++) exp_q.push_back(pay[i]);
    endtask

    task automatic push_seg(input int first, input int len);
        seg_t s;
        s.first = first;
        s.ncyc  = (8 + len) * CPB;
        seg_q.push_back(s);
    endtask

    task automatic do_start(input logic [31:0] sip, input logic [31:0] dip,
                            input logic [15:0] sp, input logic [15:0] dp,
                            input logic [15:0] len, output int s_cyc);
        src_ip_in = sip; dst_ip_in = dip; src_port_in = sp; dst_port_in = dp;
        payload_len_in = len;
        start = 1'b1;
        s_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output int acc_cyc);
        int bound;
        bound = 0;
        axiiv = 1'b1;
        axiid = b;
        while (!axiir && bound < 200) begin
            @(negedge clk);
            bound++;
        end
        check("send_byte_ready", 64'(axiir), 64'd1);
        acc_cyc = cyc;
        @(negedge clk);
        axiiv = 1'b0;
    endtask

    task automatic send_payload(input int len, input int gap, output int last_cyc);
        last_cyc = 0;
        for (int i = 0; i < len; i++) begin
            if (i > 0) repeat (gap) @(negedge clk);
            send_byte(pay[i], last_cyc);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((seg_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("segment_complete", 64'(seg_q.size() + exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_axiov();
        int n;
        n = 0;
        while (!axiov && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("axiov_seen", 64'(axiov), 64'd1);
    endtask

    // Cycle counter: value read during a cycle identifies that cycle
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expectations whenever the DUT presents output
    logic [7:0] mon_byte  = '0;
    int         mon_chunk = 0;
    int         mon_run   = 0;
    logic       mon_prev  = 1'b0;
    always @(negedge clk) begin
        logic exp_done;
        if (!rst) begin
            check("reset_outputs", 64'({axiov, axiod, axiir, done, err}), 64'd0);
            mon_prev  = 1'b0;
            mon_run   = 0;
            mon_chunk = 0;
        end else begin
            if (axiir) ir_cnt++;
            if (err) begin
                check("err_expected", 64'(exp_err > 0), 64'd1);
                if (exp_err > 0) exp_err--;
            end
            exp_done = mon_prev && !axiov;
            if (done || exp_done) check("done_pulse", 64'(done), 64'(exp_done));
            if (axiov && !mon_prev) begin
                mon_run   = 0;
                mon_chunk = 0;
                if (seg_q.size() == 0) check("axiov_unexpected", 64'(axiov), 64'd0);
                else check("first_chunk_cycle", 64'(cyc), 64'(seg_q[0].first));
            end
            if (axiov) begin
                mon_run++;
                mon_byte = (mon_byte << N) | 8'(axiod);
                mon_chunk++;
                if (mon_chunk == CPB) begin
                    mon_chunk = 0;
                    if (exp_q.size() == 0) check("byte_unexpected", 64'(axiov), 64'd0);
                    else check("byte", 64'(mon_byte), 64'(exp_q.pop_front()));
                end
            end
            if (exp_done) begin
                check("axiod_idle_zero", 64'(axiod), 64'd0);
                if (seg_q.size() != 0) check("run_length", 64'(mon_run), 64'(seg_q.pop_front().ncyc));
            end
            mon_prev = axiov;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_cyc;
        int l_cyc;
        int ir0;
        logic [15:0] ul;

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Basic segment, extra axiiv beats after the last byte
        pay[0] = 8'h01; pay[1] = 8'h02;
        foreach (v_basic[i]) exp_q.push_back(v_basic[i]);
        do_start(32'hC0A80102, 32'hC0A80101, 16'd42069, 16'd554, 16'd2, s_cyc);
        send_payload(2, 0, l_cyc);
        push_seg(l_cyc + 4, 2);
        axiiv = 1'b1; axiid = 8'hEE;
        repeat (3) @(negedge clk);
        axiiv = 1'b0;
        wait_idle();

        // Odd length, padded final byte
        pay[0] = 8'hFF;
        foreach (v_odd[i]) exp_q.push_back(v_odd[i]);
        do_start(32'hC0A80102, 32'hC0A80101, 16'd42069, 16'd554, 16'd1, s_cyc);
        send_payload(1, 0, l_cyc);
        push_seg(l_cyc + 4, 1);
        wait_idle();

        // Zero payload: no axiir at all
        ir0 = ir_cnt;
        foreach (v_zero[i]) exp_q.push_back(v_zero[i]);
        do_start(32'hC0A80102, 32'hC0A80101, 16'd42069, 16'd554, 16'd0, s_cyc);
        push_seg(s_cyc + 4, 0);
        wait_idle();
        check("zero_len_axiir", 64'(ir_cnt - ir0), 64'd0);

        // Sum inverts to zero: sent as 0xFFFF
        foreach (v_zcs[i]) exp_q.push_back(v_zcs[i]);
        do_start(32'h0, 32'h0, 16'hFFDE, 16'h0000, 16'd0, s_cyc);
        push_seg(s_cyc + 4, 0);
        wait_idle();

        // Maximum length
        for (int i = 0; i < MAX; i++) pay[i] = 8'((i * 7 + 3) ^ (i >> 2));
        push_model(32'h0A000001, 32'hFFFFFFFE, 16'h1234, 16'hFEDC, MAX);
        do_start(32'h0A000001, 32'hFFFFFFFE, 16'h1234, 16'hFEDC, 16'(MAX), s_cyc);
        send_payload(MAX, 0, l_cyc);
        push_seg(l_cyc + 4, MAX);
        wait_idle();

        // One over the limit: err only
        ir0 = ir_cnt;
        exp_err++;
        do_start(32'h0A000001, 32'h0A000002, 16'd1, 16'd2, 16'(MAX + 1), s_cyc);
        repeat (6) @(negedge clk);
        check("oversize_err_seen", 64'(exp_err), 64'd0);
        check("oversize_axiir", 64'(ir_cnt - ir0), 64'd0);

        // Input gaps and starts while busy
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        push_model(32'h01020304, 32'h05060708, 16'h0050, 16'h1F90, 3);
        do_start(32'h01020304, 32'h05060708, 16'h0050, 16'h1F90, 16'd3, s_cyc);
        send_byte(pay[0], l_cyc);
        do_start(32'hDEADBEEF, 32'hCAFEF00D, 16'h1111, 16'h2222, 16'd5, s_cyc);
        repeat (3) @(negedge clk);
        send_byte(pay[1], l_cyc);
        repeat (2) @(negedge clk);
        send_byte(pay[2], l_cyc);
        push_seg(l_cyc + 4, 3);
        wait_axiov();
        do_start(32'hDEADBEEF, 32'hCAFEF00D, 16'h1111, 16'h2222, 16'd1, s_cyc);
        wait_idle();
        repeat (20) @(negedge clk);

        // Reset mid-header, then immediate restart
        pay[0] = 8'h55; pay[1] = 8'hAA;
        push_model(32'hAC100001, 32'hAC100002, 16'd7, 16'd9, 2);
        do_start(32'hAC100001, 32'hAC100002, 16'd7, 16'd9, 16'd2, s_cyc);
        send_payload(2, 0, l_cyc);
        push_seg(l_cyc + 4, 2);
        wait_axiov();
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1 check("reset_same_cycle", 64'({axiov, axiod, done}), 64'd0);
        seg_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pay[0] = 8'h9C; pay[1] = 8'h3E; pay[2] = 8'h00; pay[3] = 8'h81;
        push_model(32'hC0A80064, 32'h08080808, 16'hC350, 16'h0035, 4);
        do_start(32'hC0A80064, 32'h08080808, 16'hC350, 16'h0035, 16'd4, s_cyc);
        send_payload(4, 1, l_cyc);
        push_seg(l_cyc + 4, 4);
        wait_idle();
        repeat (10) @(negedge clk);

        check("err_outstanding", 64'(exp_err), 64'd0);
        ul = 16'(n_checks);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
